// File: rtl/serial_sum_unadder.sv
// Bit-serial sum decoder: recovers B = S - A - cin one bit per clock, LSB first,
// and flags results that fall outside the W-bit range of B.
module serial_sum_unadder #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   sum_in,
    input  logic [W-1:0] a_in,
    input  logic         cin_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] b_out,
    output logic         range_err,
    output logic [1:0]   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on state. out_valid/b_out/range_err stay stable
    // until the out transfer, and out_valid does not depend on out_ready.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(W + 1);

    state_t          state;
    state_t          state_nxt;
    logic [W:0]      s_sh;
    logic [W:0]      a_sh;
    logic [W-1:0]    d_sh;
    logic            br;
    logic [CW-1:0]   cnt;

    logic            s_i;
    logic            a_i;
    logic            d_i;
    logic            br_nxt;
    logic            last_bit;
    logic            accept;
    logic [W:0]      d_word;

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;
    assign accept    = in_valid && in_ready;

    // One full-subtractor slice per clock; the borrow chains through br.
    assign s_i      = s_sh[0];
    assign a_i      = a_sh[0];
    assign d_i      = s_i ^ a_i ^ br;
    assign br_nxt   = (~s_i & (a_i | br)) | (a_i & br);
    assign last_bit = (cnt == CW'(W));
    assign d_word   = {d_i, d_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_sh      <= '0;
            a_sh      <= '0;
            d_sh      <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            b_out     <= '0;
            range_err <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_sh <= sum_in;
                        a_sh <= {1'b0, a_in};
                        br   <= cin_in;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    s_sh <= s_sh >> 1;
                    a_sh <= a_sh >> 1;
                    br   <= br_nxt;
                    d_sh <= {d_i, d_sh[W-1:1]};
                    cnt  <= cnt + CW'(1);
                    // Final bit: a remaining borrow means negative, d_W set means >= 2^W.
                    if (last_bit) begin
                        b_out     <= d_word[W-1:0];
                        range_err <= br_nxt | d_i;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sum_unadder.sv
// Directed bench for serial_sum_unadder: vector table, exhaustive sweeps,
// backpressure and asynchronous reset sequences.
module tb_serial_sum_unadder;

    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   sum_in;
    logic [W-1:0] a_in;
    logic         cin_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] b_out;
    logic         range_err;
    logic [1:0]   dbg_state;

    int total;
    int bad;

    logic [W:0] exp_q[$];

    typedef struct {
        logic [W:0]   s;
        logic [W-1:0] a;
        logic         c;
        logic [W-1:0] b;
        logic         err;
    } vec_t;

    vec_t vecs[9];

    serial_sum_unadder #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .a_in      (a_in),
        .cin_in    (cin_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .b_out     (b_out),
        .range_err (range_err),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, independent of the serial algorithm.
    function automatic logic [W:0] model(input logic [W:0] s, input logic [W-1:0] a, input logic c);
        int diff;
        logic [W-1:0] b;
        logic err;
        diff = int'(s) - int'(a) - int'(c);
        b    = W'(diff & ((1 << W) - 1));
        err  = (diff < 0) || (diff > (1 << W) - 1);
        return {err, b};
    endfunction

    // Driver: mode 0 = out_ready held high, 1 = random out_ready, 2 = 5-cycle backpressure.
    task automatic run_txn(input logic [W:0] s, input logic [W-1:0] a, input logic c,
                           input logic [W:0] exp, input int mode, input string tag);
        int lat;
        logic [W:0] e;
        @(negedge clk);
        check({tag, " in_ready_idle"}, 8'(in_ready), 8'd1);
        sum_in   = s;
        a_in     = a;
        cin_in   = c;
        in_valid = 1'b1;
        out_ready = (mode == 0);
        @(posedge clk);
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        sum_in   = W'($urandom) ;
        a_in     = W'($urandom);
        cin_in   = 1'($urandom);
        check({tag, " in_ready_run"}, 8'(in_ready), 8'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 8'(lat), 8'(W + 1));
        e = exp_q.pop_front();
        check({tag, " b_out"}, 8'(b_out), 8'(e[W-1:0]));
        check({tag, " range_err"}, 8'(range_err), 8'(e[W]));
        if (mode == 2) begin
            for (int i = 0; i < 5; i++) begin
                out_ready = 1'b0;
                in_valid  = 1'($urandom_range(0, 1));
                sum_in    = 4'($urandom);
                a_in      = 3'($urandom);
                cin_in    = 1'($urandom);
                @(negedge clk);
                check({tag, " bp_valid"}, 8'(out_valid), 8'd1);
                check({tag, " bp_b"}, 8'(b_out), 8'(e[W-1:0]));
                check({tag, " bp_err"}, 8'(range_err), 8'(e[W]));
                check({tag, " bp_in_ready"}, 8'(in_ready), 8'd0);
            end
            in_valid = 1'b0;
        end else if (mode == 1) begin
            for (int i = 0; i < 50; i++) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_ready) break;
                @(negedge clk);
                if (out_valid !== 1'b1 || b_out !== e[W-1:0])
                    check({tag, " hold"}, {out_valid, 4'd0, b_out}, {1'b1, 4'd0, e[W-1:0]});
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid_drop"}, 8'(out_valid), 8'd0);
        check({tag, " in_ready_back"}, 8'(in_ready), 8'd1);
        check({tag, " b_keep"}, 8'(b_out), 8'(e[W-1:0]));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = '0;
        a_in      = '0;
        cin_in    = 1'b0;

        vecs[0] = '{s: 4'd10, a: 3'd3, c: 1'b1, b: 3'd6, err: 1'b0};
        vecs[1] = '{s: 4'd2,  a: 3'd3, c: 1'b0, b: 3'd7, err: 1'b1};
        vecs[2] = '{s: 4'd0,  a: 3'd0, c: 1'b0, b: 3'd0, err: 1'b0};
        vecs[3] = '{s: 4'd15, a: 3'd0, c: 1'b0, b: 3'd7, err: 1'b1};
        vecs[4] = '{s: 4'd8,  a: 3'd0, c: 1'b1, b: 3'd7, err: 1'b0};
        vecs[5] = '{s: 4'd5,  a: 3'd2, c: 1'b0, b: 3'd3, err: 1'b0};
        vecs[6] = '{s: 4'd0,  a: 3'd0, c: 1'b1, b: 3'd7, err: 1'b1};
        vecs[7] = '{s: 4'd15, a: 3'd7, c: 1'b1, b: 3'd7, err: 1'b0};
        vecs[8] = '{s: 4'd0,  a: 3'd7, c: 1'b1, b: 3'd0, err: 1'b1};

        repeat (2) @(negedge clk);
        check("rst in_ready", 8'(in_ready), 8'd1);
        check("rst out_valid", 8'(out_valid), 8'd0);
        check("rst b_out", 8'(b_out), 8'd0);
        check("rst range_err", 8'(range_err), 8'd0);
        check("rst state", 8'(dbg_state), 8'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            run_txn(vecs[i].s, vecs[i].a, vecs[i].c, {vecs[i].err, vecs[i].b}, 0, $sformatf("vec%0d", i));

        // Backpressure, then a fresh transaction to confirm recovery.
        run_txn(4'd10, 3'd3, 1'b1, {1'b0, 3'd6}, 2, "bp");
        run_txn(4'd2, 3'd3, 1'b0, {1'b1, 3'd7}, 0, "after_bp");

        // Round trip: S built from A, B, cin must decode back to B.
        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                for (int c = 0; c < 2; c++)
                    run_txn(4'(a + b + c), 3'(a), 1'(c), {1'b0, 3'(b)}, 1, "rt");

        // Every triple, including out-of-range ones.
        for (int s = 0; s < 16; s++)
            for (int a = 0; a < 8; a++)
                for (int c = 0; c < 2; c++)
                    run_txn(4'(s), 3'(a), 1'(c), model(4'(s), 3'(a), 1'(c)), 1, "all");

        // Asynchronous reset two cycles into RUN, applied between edges.
        @(negedge clk);
        sum_in   = 4'd10;
        a_in     = 3'd3;
        cin_in   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        check("mid_run state", 8'(dbg_state), 8'd1);
        rst_n = 1'b0;
        #1;
        check("arst out_valid", 8'(out_valid), 8'd0);
        check("arst b_out", 8'(b_out), 8'd0);
        check("arst range_err", 8'(range_err), 8'd0);
        check("arst in_ready", 8'(in_ready), 8'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(4'd5, 3'd2, 1'b0, {1'b0, 3'd3}, 0, "post_rst");

        // Asynchronous reset while a result is held in DONE.
        @(negedge clk);
        sum_in   = 4'd9;
        a_in     = 3'd1;
        cin_in   = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("done_hold valid", 8'(out_valid), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_done out_valid", 8'(out_valid), 8'd0);
        check("arst_done b_out", 8'(b_out), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(4'd8, 3'd0, 1'b1, {1'b0, 3'd7}, 0, "post_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
